rle_feed_ctrl: RTL and testbench

Block-level sequencer that sits between the quantizer output and the RLE engine (`RLE_top3`). It accepts 64-bit coefficient rows over a valid/ready handshake and frames them into 8-row blocks. It forwards each row to the engine with first/last markers, then holds off upstream until the engine reports the block encoded. It also handles early block termination (flush with zero padding), counts completed blocks, and flags an engine that never finishes.

---
 rtl/rle_pkg.sv | 16 +
 rtl/rle_wdog.sv | 41 ++++
 rtl/rle_feed_ctrl.sv | 154 +++++++++++++++
 tb/tb_rle_feed_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE feed path.
package rle_pkg;

  localparam int RLE_ROW_W        = 64;   // 8 coefficients x 8 bits
  localparam int RLE_ROWS_PER_BLK = 8;
  localparam int RLE_TOP3_OUT_W   = 112;  // RLE_top3 output word width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_PAD,
    ST_WAIT,
    ST_DONE
  } rle_feed_state_t;

endpackage

// File: rtl/rle_wdog.sv
// Loadable down-counter used to bound how long we wait on the RLE engine.
// start loads TIMEOUT-1; expired is raised while enabled once the count hits 0,
// i.e. on the TIMEOUT-th enabled cycle after a start.
module rle_wdog
  import rle_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats start, start beats decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (start)
      cnt_d = LOAD;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/rle_feed_ctrl.sv
// Frames upstream coefficient rows into fixed-size blocks for the RLE engine,
// zero-pads flushed blocks, waits for the engine, counts completed blocks and
// latches a sticky error if the engine never reports done.
module rle_feed_ctrl
  import rle_pkg::*;
#(
  parameter int ROW_W        = RLE_ROW_W,
  parameter int ROWS_PER_BLK = RLE_ROWS_PER_BLK,
  parameter int TIMEOUT      = 256,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_data,
  input  logic             flush,
  output logic [ROW_W-1:0] rle_in,
  output logic             rle_load,
  output logic             rle_first,
  output logic             rle_last,
  input  logic             rle_done,
  output logic             blk_done,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             err
);

  localparam int RC_W = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1;
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(ROWS_PER_BLK - 1);

  rle_feed_state_t  state_q, state_d;
  logic [RC_W-1:0]  row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0] rle_in_q, rle_in_d;
  logic             rle_load_q, rle_load_d;
  logic             rle_first_q, rle_first_d;
  logic             rle_last_q, rle_last_d;
  logic             blk_done_q, blk_done_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             err_q, err_d;

  logic accept;
  logic wd_start, wd_clear, wd_en, wd_expired;

  // Flush wins over in_valid: dropping ready keeps the flush-cycle row out.
  assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_FEED)) && !flush;
  assign accept   = in_valid && in_ready;

  // Next-state and registered-output logic for the block sequencer.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    rle_in_d    = '0;
    rle_load_d  = 1'b0;
    rle_first_d = 1'b0;
    rle_last_d  = 1'b0;
    blk_done_d  = 1'b0;
    blk_cnt_d   = blk_cnt_q;
    err_d       = err_q;
    wd_start    = 1'b0;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rle_load_d  = 1'b1;
          rle_in_d    = in_data;
          rle_first_d = 1'b1;
          row_cnt_d   = RC_W'(1);
          state_d     = ST_FEED;
        end
      end

      // FEED forwards accepted rows; the flush cycle and every PAD cycle
      // emit a zero row instead, so padding starts without a bubble.
      ST_FEED, ST_PAD: begin
        if (accept || flush || (state_q == ST_PAD)) begin
          rle_load_d = 1'b1;
          rle_in_d   = accept ? in_data : '0;
          rle_last_d = (row_cnt_q == LAST_ROW);
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = ST_WAIT;
            wd_start  = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
            state_d   = accept ? ST_FEED : ST_PAD;
          end
        end
      end

      ST_WAIT: begin
        wd_en = 1'b1;
        if (rle_done) begin
          blk_done_d = 1'b1;
          blk_cnt_d  = blk_cnt_q + 1'b1;
          wd_clear   = 1'b1;
          state_d    = ST_DONE;
        end else if (wd_expired) begin
          err_d    = 1'b1;
          wd_clear = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any partial block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      rle_in_q    <= '0;
      rle_load_q  <= 1'b0;
      rle_first_q <= 1'b0;
      rle_last_q  <= 1'b0;
      blk_done_q  <= 1'b0;
      blk_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      rle_in_q    <= rle_in_d;
      rle_load_q  <= rle_load_d;
      rle_first_q <= rle_first_d;
      rle_last_q  <= rle_last_d;
      blk_done_q  <= blk_done_d;
      blk_cnt_q   <= blk_cnt_d;
      err_q       <= err_d;
    end
  end

  rle_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .start   (wd_start),
    .clear   (wd_clear),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign rle_in    = rle_in_q;
  assign rle_load  = rle_load_q;
  assign rle_first = rle_first_q;
  assign rle_last  = rle_last_q;
  assign blk_done  = blk_done_q;
  assign blk_cnt   = blk_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rle_feed_ctrl.sv
// Bench for rle_feed_ctrl: builds the expected engine-side row stream per
// block (accepted rows, then zero padding, with cycle stamps) and compares it
// with what the DUT emits; also tracks the block count and sticky error.
module tb_rle_feed_ctrl;

  localparam int ROW_W   = 64;
  localparam int ROWS    = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic             rle_done = 1'b0;
  logic [ROW_W-1:0] in_data = '0;
  logic             in_ready, rle_load, rle_first, rle_last, blk_done, err;
  logic [ROW_W-1:0] rle_in;
  logic [CNT_W-1:0] blk_cnt;

  typedef struct {
    int               cyc;
    logic [ROW_W-1:0] data;
    logic             first;
    logic             last;
  } ev_t;

  ev_t mon_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  nz_viol = 0;
  int  done_pulses = 0;
  int  pass_n = 0;
  int  chk_n = 0;
  logic [CNT_W-1:0] cnt_m = '0;
  logic             err_m = 1'b0;

  rle_feed_ctrl #(
    .ROW_W(ROW_W), .ROWS_PER_BLK(ROWS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .rle_in(rle_in), .rle_load(rle_load),
    .rle_first(rle_first), .rle_last(rle_last), .rle_done(rle_done),
    .blk_done(blk_done), .blk_cnt(blk_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Cycle index; a row driven in cycle c should be seen by the monitor in c+1.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every engine load with its cycle; note nonzero data on idle cycles.
  always @(negedge clk) begin
    if (rle_load === 1'b1) begin
      mon_e.cyc = cyc; mon_e.data = rle_in; mon_e.first = rle_first; mon_e.last = rle_last;
      mon_q.push_back(mon_e);
    end else if (rle_in !== '0) begin
      nz_viol++;
    end
    if (blk_done === 1'b1) done_pulses++;
  end

  // mode: 0 = valid every cycle, 1 = valid pattern 1,0,0, 2 = random bubbles.
  // nrows < ROWS flushes after that many rows; dly < 0 never answers rle_done.
  task automatic run_block(input int nrows, input int mode, input int dly,
                           input bit fixed, input bit noise);
    ev_t exp_q[$];
    ev_t e;
    int acc = 0, step = 0, lim, last_cyc;
    int base = mon_q.size();
    int dp0 = done_pulses;
    while (acc < nrows) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = (step % 3 == 0);
        default: in_valid = ($urandom_range(99) >= 40);
      endcase
      in_data  = fixed ? ((acc == 0) ? 64'h4204_0000_0000_0000 : '0) : {$urandom, $urandom};
      flush    = 1'b0;
      rle_done = noise ? 1'($urandom_range(1)) : 1'b0;
      #1;
      chk_n++; if (in_ready !== 1'b1) $display("FAIL feed_ready: in_ready=%b want 1 (cycle %0d)", in_ready, cyc); else pass_n++;
      if (in_valid) begin
        e.cyc = cyc + 1; e.data = in_data; e.first = (acc == 0); e.last = (acc == ROWS - 1);
        exp_q.push_back(e);
        acc++;
      end
      step++;
      @(negedge clk);
    end
    if (nrows < ROWS) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; flush = 1'b1; rle_done = 1'b0;
      #1;
      chk_n++; if (in_ready !== 1'b0) $display("FAIL flush_ready: in_ready=%b want 0", in_ready); else pass_n++;
      for (int j = nrows; j < ROWS; j++) begin
        e.cyc = cyc + 1 + (j - nrows); e.data = '0; e.first = (j == 0); e.last = (j == ROWS - 1);
        exp_q.push_back(e);
      end
      @(negedge clk);
      flush = 1'b0;
    end
    last_cyc = exp_q[ROWS-1].cyc;
    lim = (dly < 0) ? last_cyc + TIMEOUT : last_cyc + dly;
    while (cyc < lim) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; rle_done = 1'b0;
      #1;
      chk_n++; if (in_ready !== 1'b0) $display("FAIL wait_ready: in_ready=%b want 0 (cycle %0d)", in_ready, cyc); else pass_n++;
      chk_n++; if (err !== err_m) $display("FAIL err_hold: err=%b want %b (cycle %0d)", err, err_m, cyc); else pass_n++;
      @(negedge clk);
    end
    if (dly >= 0) begin
      rle_done = 1'b1;
      #1;
      chk_n++; if (in_ready !== 1'b0) $display("FAIL done_cycle_ready: in_ready=%b want 0", in_ready); else pass_n++;
      @(negedge clk);
      rle_done = 1'b0; in_valid = 1'b0; cnt_m = cnt_m + 1'b1;
      #1;
      chk_n++; if (blk_done !== 1'b1) $display("FAIL blk_done: blk_done=%b want 1", blk_done); else pass_n++;
      chk_n++; if (blk_cnt !== cnt_m) $display("FAIL blk_cnt: blk_cnt=%0d want %0d", blk_cnt, cnt_m); else pass_n++;
      chk_n++; if (in_ready !== 1'b0) $display("FAIL done_state_ready: in_ready=%b want 0", in_ready); else pass_n++;
      @(negedge clk);
      #1;
      chk_n++; if (blk_done !== 1'b0) $display("FAIL blk_done_width: blk_done=%b want 0", blk_done); else pass_n++;
      chk_n++; if (in_ready !== 1'b1) $display("FAIL idle_ready: in_ready=%b want 1", in_ready); else pass_n++;
      chk_n++; if (done_pulses - dp0 !== 1) $display("FAIL done_count: pulses=%0d want 1", done_pulses - dp0); else pass_n++;
    end else begin
      in_valid = 1'b0;
      #1;
      chk_n++; if (err !== 1'b1) $display("FAIL timeout_err: err=%b want 1", err); else pass_n++;
      chk_n++; if (in_ready !== 1'b1) $display("FAIL timeout_idle: in_ready=%b want 1", in_ready); else pass_n++;
      chk_n++; if (blk_cnt !== cnt_m) $display("FAIL timeout_cnt: blk_cnt=%0d want %0d", blk_cnt, cnt_m); else pass_n++;
      chk_n++; if (done_pulses !== dp0) $display("FAIL timeout_no_done: pulses=%0d want 0", done_pulses - dp0); else pass_n++;
      err_m = 1'b1;
    end
    chk_n++; if (mon_q.size() - base !== ROWS) $display("FAIL load_count: loads=%0d want %0d", mon_q.size() - base, ROWS); else pass_n++;
    for (int i = 0; i < ROWS && base + i < mon_q.size(); i++) begin
      chk_n++;
      if (mon_q[base+i].cyc !== exp_q[i].cyc || mon_q[base+i].data !== exp_q[i].data ||
          mon_q[base+i].first !== exp_q[i].first || mon_q[base+i].last !== exp_q[i].last)
        $display("FAIL row%0d: got cyc=%0d data=%h first=%b last=%b want cyc=%0d data=%h first=%b last=%b",
                 i, mon_q[base+i].cyc, mon_q[base+i].data, mon_q[base+i].first, mon_q[base+i].last,
                 exp_q[i].cyc, exp_q[i].data, exp_q[i].first, exp_q[i].last);
      else pass_n++;
    end
    chk_n++; if (nz_viol !== 0) $display("FAIL idle_zero: nonzero rle_in cycles=%0d want 0", nz_viol); else pass_n++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; rle_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_n++; if (rle_load !== 1'b0 || rle_first !== 1'b0 || rle_last !== 1'b0) $display("FAIL reset_flags: load=%b first=%b last=%b want 0", rle_load, rle_first, rle_last); else pass_n++;
    chk_n++; if (rle_in !== '0) $display("FAIL reset_rle_in: rle_in=%h want 0", rle_in); else pass_n++;
    chk_n++; if (blk_done !== 1'b0 || blk_cnt !== '0 || err !== 1'b0) $display("FAIL reset_status: done=%b cnt=%0d err=%b want 0", blk_done, blk_cnt, err); else pass_n++;
    reset = 1'b0;
    #1;
    chk_n++; if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b want 1", in_ready); else pass_n++;
    cnt_m = '0; err_m = 1'b0;
  endtask

  task automatic test_full_block();
    run_block(ROWS, 0, 3, 1'b1, 1'b0);
    chk_n++; if (blk_cnt !== 2'd1) $display("FAIL full_block_cnt: blk_cnt=%0d want 1", blk_cnt); else pass_n++;
  endtask

  task automatic test_flush();
    // Flush while idle does nothing but hold off the row offered with it.
    flush = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom};
    #1;
    chk_n++; if (in_ready !== 1'b0) $display("FAIL idle_flush_ready: in_ready=%b want 0", in_ready); else pass_n++;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk_n++; if (rle_load !== 1'b0) $display("FAIL idle_flush_load: rle_load=%b want 0", rle_load); else pass_n++;
    chk_n++; if (in_ready !== 1'b1) $display("FAIL idle_flush_idle: in_ready=%b want 1", in_ready); else pass_n++;
    run_block(3, 0, 3, 1'b0, 1'b0);
    run_block(7, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_bubbles();
    run_block(ROWS, 1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_block(ROWS, 0, -1, 1'b0, 1'b0);
    run_block(ROWS, 0, 2, 1'b0, 1'b0);
    chk_n++; if (err !== 1'b1) $display("FAIL err_sticky: err=%b want 1", err); else pass_n++;
  endtask

  task automatic test_reset_mid_feed();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = {$urandom, $urandom}; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk_n++; if (rle_load !== 1'b0 || rle_first !== 1'b0 || rle_last !== 1'b0 || rle_in !== '0) $display("FAIL midreset_out: load=%b first=%b last=%b rle_in=%h want 0", rle_load, rle_first, rle_last, rle_in); else pass_n++;
    chk_n++; if (blk_done !== 1'b0 || blk_cnt !== '0 || err !== 1'b0) $display("FAIL midreset_status: done=%b cnt=%0d err=%b want 0", blk_done, blk_cnt, err); else pass_n++;
    chk_n++; if (in_ready !== 1'b1) $display("FAIL midreset_ready: in_ready=%b want 1", in_ready); else pass_n++;
    cnt_m = '0; err_m = 1'b0;
    run_block(ROWS, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt_m = '0; err_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_block((i == 2) ? 4 : ROWS, i % 2, i, 1'b0, 1'b0);
      chk_n++; if (blk_cnt !== CNT_W'(seq[i])) $display("FAIL wrap_cnt%0d: blk_cnt=%0d want %0d", i, blk_cnt, seq[i]); else pass_n++;
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 20; b++)
      run_block($urandom_range(1, ROWS), 2,
                ($urandom_range(9) == 0) ? -1 : $urandom_range(0, 5), 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_flush();
    test_bubbles();
    test_timeout();
    test_reset_mid_feed();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, checks passed=%0d of %0d", pass_n, chk_n);
    $fatal(1);
  end

endmodule
